seq_signed_or_unsigned_mul: RTL

Parametrised, iterative (radix-2 shift-add) N×N multiplier producing a 2N-bit product. A per-operation `sign` bit selects two's-complement or unsigned interpretation. Operands and result move over valid/ready handshakes, so the block sits between a producer and a consumer in a datapath where one product every N+2 cycles is sufficient and area matters more than latency. It is the multi-cycle, flow-controlled replacement for the purely combinational signed/unsigned multipliers.

---
 rtl/seq_signed_or_unsigned_mul_pkg.sv | 15 +
 rtl/seq_signed_or_unsigned_mul_abs_n.sv | 15 +
 rtl/seq_signed_or_unsigned_mul.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_signed_or_unsigned_mul_pkg.sv
// Shared types for the iterative signed/unsigned multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Step counter only has to reach n-1, so log2(n) bits suffice.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_signed_or_unsigned_mul_abs_n.sv
// Operand magnitude: two's-complement absolute value when sign is set, raw value otherwise.
module abs_n #(
    parameter int n = 8
) (
    input  logic [n-1:0] value,
    input  logic         sign,
    output logic [n-1:0] mag,
    output logic         neg
);

    assign neg = sign & value[n-1];
    // -(-2^(n-1)) wraps to 2^(n-1), which is exactly the unsigned magnitude we want.
    assign mag = neg ? -value : value;

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Radix-2 shift-add N x N multiplier with valid/ready on both sides and per-op sign mode.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operation
//   BUSY  | one multiplier bit per cycle, LSB first
//   DONE  | out_valid high, res held until out_ready
module seq_signed_or_unsigned_mul
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           sign,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*n-1:0] res
);

    localparam int            cw        = cnt_width(n);
    localparam logic [cw-1:0] last_step = cw'(n - 1);

    state_t           state;
    logic [cw-1:0]    step;
    logic [2*n-1:0]   acc;
    logic [2*n-1:0]   mcand;
    logic [n-1:0]     mplier;
    logic             res_neg;
    logic             mode;

    logic [n-1:0]     mag_a;
    logic [n-1:0]     mag_b;
    logic             neg_a;
    logic             neg_b;
    logic [2*n-1:0]   sum;

    abs_n #(.n(n)) u_abs_a (
        .value (a),
        .sign  (sign),
        .mag   (mag_a),
        .neg   (neg_a)
    );

    abs_n #(.n(n)) u_abs_b (
        .value (b),
        .sign  (sign),
        .mag   (mag_b),
        .neg   (neg_b)
    );

    assign sum = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            step      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            res_neg   <= 1'b0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{n{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        res_neg  <= neg_a ^ neg_b;
                        mode     <= sign;
                        acc      <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + cw'(1);
                    // The last partial product goes straight into res, saving a cycle.
                    if (step == last_step) begin
                        res       <= (mode & res_neg) ? -sum : sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
